// File: rtl/estufa_planta_if.sv
// Plant-side bundle for the greenhouse climate loop: actuator commands in, sensors/temperature out.
// The controller drives the master modport and the plant model uses the slave modport.
interface estufa_planta_if #(
  parameter int NBITS_TEMP = 8
);
  logic                  heater;
  logic                  cooler;
  logic                  drift_en;
  logic                  load;
  logic [NBITS_TEMP-1:0] load_val;
  logic                  fault_t1;
  logic                  t1;
  logic                  t2;
  logic [NBITS_TEMP-1:0] temp;
  logic                  tick;

  modport master (
    output heater, cooler, drift_en, load, load_val, fault_t1,
    input  t1, t2, temp, tick
  );

  modport slave (
    input  heater, cooler, drift_en, load, load_val, fault_t1,
    output t1, t2, temp, tick
  );
endinterface

// File: rtl/estufa_planta.sv
// Greenhouse plant model: integrates heater/cooler commands into a temperature and drives the
// registered T1/T2 threshold sensors. Define PLANTA_FAULT_EN to let fault_t1 force T1 low.
module estufa_planta #(
  parameter int NBITS_TEMP = 8,
  parameter int T_LOW      = 18,
  parameter int T_HIGH     = 28,
  parameter int T_AMB      = 22,
  parameter int T_RESET    = 22,
  parameter int STEP_DIV   = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  estufa_planta_if.slave   bus
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0]         CNT_LAST = CW'(STEP_DIV - 1);
  localparam logic [NBITS_TEMP-1:0] TEMP_MAX = '1;
  localparam logic [NBITS_TEMP-1:0] LOW_V    = NBITS_TEMP'(T_LOW);
  localparam logic [NBITS_TEMP-1:0] HIGH_V   = NBITS_TEMP'(T_HIGH);
  localparam logic [NBITS_TEMP-1:0] AMB_V    = NBITS_TEMP'(T_AMB);
  localparam logic [NBITS_TEMP-1:0] RESET_V  = NBITS_TEMP'(T_RESET);

  logic [CW-1:0]         cnt_q, cnt_next;
  logic                  tick_q;
  logic [NBITS_TEMP-1:0] temp_q, temp_next;
  logic                  t1_q, t2_q;
  logic                  fault_eff;

`ifdef PLANTA_FAULT_EN
  assign fault_eff = bus.fault_t1;
`else
  logic unused_fault_t1;
  assign unused_fault_t1 = bus.fault_t1;
  assign fault_eff       = 1'b0;
`endif

  assign cnt_next = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);

  // tick_q marks the cycle whose closing edge applies a temperature step.
  always_comb begin
    // NOTE: default first so every path assigns temp_next and no latch is inferred.
    temp_next = temp_q;
    if (bus.load) begin
      temp_next = bus.load_val;
    end else if (tick_q) begin
      unique case ({bus.heater, bus.cooler})
        2'b10: if (temp_q != TEMP_MAX) temp_next = temp_q + NBITS_TEMP'(1);
        2'b01: if (temp_q != '0)       temp_next = temp_q - NBITS_TEMP'(1);
        default: begin
          if (bus.drift_en) begin
            if (temp_q < AMB_V)      temp_next = temp_q + NBITS_TEMP'(1);
            else if (temp_q > AMB_V) temp_next = temp_q - NBITS_TEMP'(1);
          end
        end
      endcase
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values of its peers.
  always_ff @(posedge clk_2) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      temp_q <= RESET_V;
      t1_q   <= (RESET_V >= LOW_V);
      t2_q   <= (RESET_V >= HIGH_V);
    end else begin
      cnt_q  <= cnt_next;
      tick_q <= (cnt_next == CNT_LAST);
      temp_q <= temp_next;
      // Sensors follow the current register, so they lag a temperature change by one cycle.
      t1_q   <= (temp_q >= LOW_V) & ~fault_eff;
      t2_q   <= (temp_q >= HIGH_V);
    end
  end

  assign bus.temp = temp_q;
  assign bus.tick = tick_q;
  assign bus.t1   = t1_q;
  assign bus.t2   = t2_q;

endmodule

// File: tb/tb_estufa_planta.sv
// Directed bench for estufa_planta with default parameters (T_RESET=22, STEP_DIV=4).
// Inputs change and outputs are sampled 1 time unit after each rising clk_2 edge.
module tb_estufa_planta;

  localparam int NB       = 8;
  localparam int STEP_DIV = 4;

  logic clk_2 = 1'b0;
  logic reset = 1'b0;

  estufa_planta_if #(.NBITS_TEMP(NB)) bus ();

  estufa_planta #(
    .NBITS_TEMP(NB), .T_LOW(18), .T_HIGH(28), .T_AMB(22), .T_RESET(22), .STEP_DIV(STEP_DIV)
  ) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2 = ~clk_2;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  // Advance until n tick cycles have been closed by a clock edge.
  task automatic run_ticks(input int n, input string tag);
    int seen = 0;
    int budget = 0;
    while (seen < n && budget < n * STEP_DIV + 10) begin
      if (bus.tick) seen++;
      step();
      budget++;
    end
    check({tag, "_ticks_seen"}, seen, n);
  endtask

  task automatic do_load(input int v);
    bus.load     = 1'b1;
    bus.load_val = NB'(v);
    step();
    bus.load     = 1'b0;
  endtask

  initial begin
    int cyc;
    int t28_cyc;
    int t2_cyc;
    int t1_dropped;

    bus.heater = 0; bus.cooler = 0; bus.drift_en = 0;
    bus.load = 0; bus.load_val = '0; bus.fault_t1 = 0;

    // Reset state
    repeat (3) step();
    check("rst_temp", bus.temp, 22);
    check("rst_t1",   bus.t1, 1);
    check("rst_t2",   bus.t2, 0);
    check("rst_tick", bus.tick, 0);

    // Released cycle is cycle 1; the tick lands on cycle STEP_DIV, i.e. STEP_DIV-1 edges later.
    reset = 1'b1;
    cyc = 0;
    while (!bus.tick && cyc < 20) begin
      step();
      cyc++;
    end
    check("first_tick_edges", cyc, STEP_DIV - 1);
    step();
    check("tick_one_cycle", bus.tick, 0);

    // Heating 40 ticks from 22 -> 62, t2 one cycle after temp hits 28
    bus.heater = 1'b1;
    t28_cyc = -1; t2_cyc = -1; t1_dropped = 0; cyc = 0;
    begin
      int seen = 0;
      while (seen < 40 && cyc < 400) begin
        if (bus.tick) seen++;
        step();
        cyc++;
        if (bus.temp == 28 && t28_cyc < 0) t28_cyc = cyc;
        if (bus.t2 && t2_cyc < 0) t2_cyc = cyc;
        if (!bus.t1) t1_dropped = 1;
      end
      check("heat_ticks_seen", seen, 40);
    end
    bus.heater = 1'b0;
    check("heat_temp", bus.temp, 62);
    check("heat_t2_delay", t2_cyc - t28_cyc, 1);
    check("heat_t1_stable", t1_dropped, 0);
    check("heat_t2", bus.t2, 1);

    // Load 1, cool 5 ticks -> saturate at 0
    do_load(1);
    check("load1_temp", bus.temp, 1);
    check("load1_t1_lag", bus.t1, 1);
    step();
    check("load1_t1", bus.t1, 0);
    bus.cooler = 1'b1;
    run_ticks(5, "cool");
    check("cool_sat0", bus.temp, 0);
    bus.cooler = 1'b0;

    // Load 255, heat -> saturate at 255
    do_load(255);
    bus.heater = 1'b1;
    run_ticks(2, "heatmax");
    check("heat_sat255", bus.temp, 255);
    bus.heater = 1'b0;

    // Both commands, drift on: 30 -> 22 over 8 ticks, then hold
    do_load(30);
    bus.heater = 1'b1; bus.cooler = 1'b1; bus.drift_en = 1'b1;
    run_ticks(4, "drift_a");
    check("drift_mid", bus.temp, 26);
    run_ticks(4, "drift_b");
    check("drift_amb", bus.temp, 22);
    run_ticks(3, "drift_c");
    check("drift_hold", bus.temp, 22);

    // Both commands, drift off: hold at 30
    bus.drift_en = 1'b0;
    do_load(30);
    run_ticks(4, "nodrift");
    check("nodrift_hold", bus.temp, 30);
    bus.heater = 1'b0; bus.cooler = 1'b0;

    // Load beats a heating tick
    cyc = 0;
    while (!bus.tick && cyc < 20) begin
      step();
      cyc++;
    end
    check("load_tick_seen", bus.tick, 1);
    bus.heater = 1'b1;
    do_load(10);
    bus.heater = 1'b0;
    check("load_wins", bus.temp, 10);

    // Reset beats load
    reset = 1'b0;
    bus.load = 1'b1; bus.load_val = NB'(99);
    step();
    bus.load = 1'b0;
    check("rst_over_load", bus.temp, 22);
    check("rst_tick2", bus.tick, 0);
    reset = 1'b1;

    // Fault request at temp=30
    do_load(30);
    step();
    step();
    bus.fault_t1 = 1'b1;
    step();
`ifdef PLANTA_FAULT_EN
    check("fault_t1", bus.t1, 0);
`else
    check("fault_t1", bus.t1, 1);
`endif
    check("fault_t2", bus.t2, 1);
    bus.fault_t1 = 1'b0;
    step();
    check("fault_clear_t1", bus.t1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
